// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, defaults and round-robin search for btn_event_arbiter
package btn_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } btn_state_e;

  localparam int HOLD_W_DEFAULT = 4;

  // First set bit of mask scanning upward from ptr, wrapping at n (n <= 16).
  function automatic logic [3:0] rr_find(input logic [15:0] mask,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && mask[idx[3:0]]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_tracker.sv
// rtl/btn_tracker.sv - per-button edge, hold counter and pending-event flags
module btn_tracker
  import btn_pkg::*;
#(
  parameter int HOLD_W = HOLD_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_clr_press,
  input  logic i_clr_long,
  output logic o_press_pend,
  output logic o_long_pend
);

  logic              r_prev;
  logic [HOLD_W-1:0] r_hold;
  logic              r_long_done;
  logic              r_press_pend;
  logic              r_long_pend;

  logic w_edge;
  logic w_hold_full;
  logic w_long_fire;

  assign w_edge      = i_btn & ~r_prev;
  assign w_hold_full = &r_hold;
  assign w_long_fire = i_btn & w_hold_full & ~r_long_done;

  // New events take priority over a same-cycle grant clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= 1'b0;
      r_hold       <= '0;
      r_long_done  <= 1'b0;
      r_press_pend <= 1'b0;
      r_long_pend  <= 1'b0;
    end else begin
      r_prev <= i_btn;

      if (!i_btn || w_edge)
        r_hold <= '0;
      else if (!w_hold_full)
        r_hold <= r_hold + 1'b1;

      if (!i_btn)
        r_long_done <= 1'b0;
      else if (w_long_fire)
        r_long_done <= 1'b1;

      if (w_edge)
        r_press_pend <= 1'b1;
      else if (i_clr_press)
        r_press_pend <= 1'b0;

      if (w_long_fire)
        r_long_pend <= 1'b1;
      else if (i_clr_long)
        r_long_pend <= 1'b0;
    end
  end

  assign o_press_pend = r_press_pend;
  assign o_long_pend  = r_long_pend;

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - press/long-press events from N buttons, round-robin served over valid/ready
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int HOLD_W = HOLD_W_DEFAULT,
  localparam int IDW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_long,
  output logic [N-1:0]   pending
);

  btn_state_e     r_state;
  btn_state_e     w_state_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_evt_id;
  logic           r_evt_long;

  logic [N-1:0]   w_press_pend;
  logic [N-1:0]   w_long_pend;
  logic [N-1:0]   w_clr_press;
  logic [N-1:0]   w_clr_long;
  logic [IDW-1:0] w_sel;
  logic           w_sel_long;
  logic           w_grant;

  for (genvar g = 0; g < N; g++) begin : g_trk
    btn_tracker #(
      .HOLD_W(HOLD_W)
    ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .i_btn       (btn[g]),
      .i_clr_press (w_clr_press[g]),
      .i_clr_long  (w_clr_long[g]),
      .o_press_pend(w_press_pend[g]),
      .o_long_pend (w_long_pend[g])
    );
  end

  assign pending    = w_press_pend | w_long_pend;
  assign w_sel      = IDW'(rr_find(16'(pending), 4'(r_rr_ptr), N));
  assign w_sel_long = ~w_press_pend[w_sel];

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_clr_press  = '0;
    w_clr_long   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|pending) begin
          w_grant = 1'b1;
          if (w_sel_long)
            w_clr_long[w_sel] = 1'b1;
          else
            w_clr_press[w_sel] = 1'b1;
          w_state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_evt_id   <= '0;
      r_evt_long <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_evt_id   <= w_sel;
        r_evt_long <= w_sel_long;
      end
      // Explicit wrap so non-power-of-two N never points past the last button.
      if ((r_state == ST_OFFER) && evt_ready) begin
        if (r_evt_id == IDW'(N - 1))
          r_rr_ptr <= '0;
        else
          r_rr_ptr <= r_evt_id + 1'b1;
      end
    end
  end

  assign evt_valid = (r_state == ST_OFFER);
  assign evt_id    = r_evt_id;
  assign evt_long  = r_evt_long;

endmodule
